// File: rtl/vram_write_fifo.sv
// vram_write_fifo: queues CPU stores that land in the VRAM window and drains them to the VGA write port,
// optionally only during vertical blank, with a memory-mapped status/control word.
module vram_write_fifo #(
    parameter int          DEPTH     = 16,
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 16,
    parameter logic [31:0] VRAM_BASE = 32'hFFF00000,
    parameter logic [31:0] STATUS_AD = 32'hFFFFFFF8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       iobus_addr,
    input  logic [31:0]       iobus_out,
    input  logic              iobus_wr,
    output logic [31:0]       status_rdata,
    input  logic              vblank,
    input  logic              gate_vblank,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_data,
    output logic              vram_wen
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [32:0] WIN_LO = {1'b0, VRAM_BASE};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << ADDR_W);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [PW:0]              count;
    logic                     overflow;
    logic [7:0]               drop_cnt;
    logic                     in_win, empty, full, pop, push, drop, clr;
    logic [31:0]              status;

    always_comb begin
        in_win = iobus_wr && {1'b0, iobus_addr} >= WIN_LO && {1'b0, iobus_addr} < WIN_HI;
        empty  = count == '0;
        full   = count == FULL_CNT;
        pop    = !empty && (!gate_vblank || vblank);
        // a pop frees the head slot this cycle, so a store into a full FIFO is still accepted
        push   = in_win && (!full || pop);
        drop   = in_win && full && !pop;
        clr    = iobus_wr && iobus_addr == STATUS_AD && iobus_out[0];
        status = '0;
        status[0] = empty;
        status[1] = full;
        status[2] = overflow;
        status[15:8] = drop_cnt;
        status[16 +: PW+1] = count;
        status_rdata = iobus_addr == STATUS_AD ? status : '0;
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {iobus_addr[ADDR_W+1:2], iobus_out[DATA_W-1:0]};

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
            vram_wen  <= 1'b0;
            vram_addr <= '0;
            vram_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (pop) {vram_addr, vram_data} <= mem[rd_ptr];
            count    <= count + (PW+1)'(push) - (PW+1)'(pop);
            vram_wen <= pop;
            overflow <= drop || (overflow && !clr);
            drop_cnt <= drop ? (clr ? 8'd1 : drop_cnt + {7'd0, drop_cnt != 8'hFF}) : clr ? 8'd0 : drop_cnt;
        end
endmodule

// File: tb/tb_vram_write_fifo.sv
// tb_vram_write_fifo: scenario tasks driving vram_write_fifo against a queue-based reference model.
module tb_vram_write_fifo;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'hFFF00000;
    localparam logic [31:0] WEND  = 32'hFFF40000;
    localparam logic [31:0] STAT  = 32'hFFFFFFF8;

    logic        clk = 0, reset = 1;
    logic [31:0] iobus_addr = 0, iobus_out = 0;
    logic        iobus_wr = 0, vblank = 0, gate_vblank = 0;
    logic [31:0] status_rdata;
    logic [15:0] vram_addr;
    logic [31:0] vram_data;
    logic        vram_wen;

    int checks = 0, failures = 0;
    logic [47:0] mq[$];
    bit          m_ovf = 0, mon_on = 0, exp_wen = 0;
    logic [7:0]  m_drop = 0;
    logic [15:0] exp_addr = 0;
    logic [31:0] exp_data = 0;

    vram_write_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .iobus_addr(iobus_addr), .iobus_out(iobus_out),
        .iobus_wr(iobus_wr), .status_rdata(status_rdata), .vblank(vblank),
        .gate_vblank(gate_vblank), .vram_addr(vram_addr), .vram_data(vram_data), .vram_wen(vram_wen)
    );

    always #5 clk = ~clk;

    // scoreboard on the VGA port: every cycle must match the model's expected output registers
    always @(negedge clk)
        if (mon_on) begin
            checks++;
            if (vram_wen !== exp_wen || vram_addr !== exp_addr || vram_data !== exp_data) begin
                failures++;
                $display("FAIL vram_port t=%0t got wen=%b addr=%h data=%h want wen=%b addr=%h data=%h",
                         $time, vram_wen, vram_addr, vram_data, exp_wen, exp_addr, exp_data);
            end
        end

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[0] = mq.size() == 0;
        s[1] = mq.size() == DEPTH;
        s[2] = m_ovf;
        s[15:8] = m_drop;
        s[20:16] = 5'(mq.size());
        return s;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_ovf = 0;
        m_drop = 0;
        exp_wen = 0;
        exp_addr = 0;
        exp_data = 0;
    endtask

    task automatic step(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit vb, input bit g);
        bit pop, win, clr;
        logic [47:0] e;
        iobus_wr = wr; iobus_addr = a; iobus_out = d; vblank = vb; gate_vblank = g;
        pop = mq.size() > 0 && (!g || vb);
        win = wr && a >= BASE && a < WEND;
        clr = wr && a == STAT && d[0];
        @(posedge clk);
        exp_wen = pop;
        if (pop) begin
            e = mq.pop_front();
            exp_addr = e[47:32];
            exp_data = e[31:0];
        end
        if (win) begin
            if (mq.size() < DEPTH) mq.push_back({a[17:2], d});
            else begin
                m_ovf = 1;
                m_drop = (m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1;
            end
        end else if (clr) begin
            m_ovf = 0;
            m_drop = 0;
        end
        #1;
    endtask

    task automatic peek(input logic [31:0] a);
        iobus_wr = 0;
        iobus_addr = a;
        #1;
    endtask

    task automatic test_reset();
        model_clear();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (vram_wen !== 0 || vram_addr !== 0 || vram_data !== 0) begin
            failures++;
            $display("FAIL reset_outputs got wen=%b addr=%h data=%h want 0", vram_wen, vram_addr, vram_data);
        end
        reset = 0;
        mon_on = 1;
        peek(STAT);
        checks++;
        if (status_rdata !== 32'h1) begin
            failures++;
            $display("FAIL reset_status got %h want 00000001", status_rdata);
        end
        peek(32'hFFFFFFF4);
        checks++;
        if (status_rdata !== 32'h0) begin
            failures++;
            $display("FAIL status_unaddressed got %h want 00000000", status_rdata);
        end
    endtask

    task automatic test_latency();
        step(1, 32'hFFF00104, 32'hDEADBEEF, 0, 0);
        checks++;
        if (vram_wen !== 0) begin
            failures++;
            $display("FAIL latency_c0 got wen=%b want 0", vram_wen);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (vram_wen !== 1 || vram_addr !== 16'h0041 || vram_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL latency_c1 got wen=%b addr=%h data=%h want 1/0041/deadbeef", vram_wen, vram_addr, vram_data);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (vram_wen !== 0 || vram_addr !== 16'h0041) begin
            failures++;
            $display("FAIL latency_c2 got wen=%b addr=%h want 0/0041", vram_wen, vram_addr);
        end
    endtask

    task automatic test_vblank_gate();
        for (int i = 0; i < 5; i++) step(1, BASE + 32'(4 * i), $urandom, 0, 1);
        repeat (2) step(0, 0, 0, 0, 1);
        peek(STAT);
        checks++;
        if (status_rdata !== 32'h00050000) begin
            failures++;
            $display("FAIL gate_count got %h want 00050000", status_rdata);
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1, 1);
            checks++;
            if (vram_wen !== (i < 5) || (i < 5 && vram_addr !== 16'(i))) begin
                failures++;
                $display("FAIL gate_drain_%0d got wen=%b addr=%h want wen=%b addr=%h", i, vram_wen, vram_addr, i < 5, i);
            end
        end
        peek(STAT);
        checks++;
        if (status_rdata !== 32'h1) begin
            failures++;
            $display("FAIL gate_empty got %h want 00000001", status_rdata);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 3; i++) step(1, BASE + 32'($urandom_range(0, 32'h3FFFF)), $urandom, 0, 1);
        peek(STAT);
        checks++;
        if (status_rdata !== 32'h00100306) begin
            failures++;
            $display("FAIL overflow_status got %h want 00100306", status_rdata);
        end
    endtask

    task automatic test_full_pop();
        step(1, 32'hFFF00ABC, 32'h12345678, 1, 1);
        peek(STAT);
        checks++;
        if (status_rdata !== 32'h00100306) begin
            failures++;
            $display("FAIL full_pop_status got %h want 00100306", status_rdata);
        end
        repeat (DEPTH + 3) step(0, 0, 0, 1, 1);
        peek(STAT);
        checks++;
        if (status_rdata !== 32'h00000305) begin
            failures++;
            $display("FAIL full_pop_drained got %h want 00000305", status_rdata);
        end
    endtask

    task automatic test_filter();
        step(1, WEND, 32'h11111111, 0, 0);
        step(1, BASE - 4, 32'h22222222, 0, 0);
        step(1, STAT, 32'h0, 0, 0);
        step(0, 0, 0, 0, 0);
        peek(STAT);
        checks++;
        if (status_rdata !== 32'h00000305) begin
            failures++;
            $display("FAIL filter_status got %h want 00000305", status_rdata);
        end
        step(1, STAT, 32'h1, 0, 0);
        peek(STAT);
        checks++;
        if (status_rdata !== 32'h1) begin
            failures++;
            $display("FAIL clear_status got %h want 00000001", status_rdata);
        end
        for (int i = 0; i < DEPTH + 1; i++) step(1, BASE + 32'(4 * i), $urandom, 0, 1);
        peek(STAT);
        checks++;
        if (status_rdata !== 32'h00100106) begin
            failures++;
            $display("FAIL drop_after_clear got %h want 00100106", status_rdata);
        end
        repeat (260) step(1, BASE + 32'h40, $urandom, 0, 1);
        peek(STAT);
        checks++;
        if (status_rdata !== 32'h0010FF06) begin
            failures++;
            $display("FAIL drop_saturate got %h want 0010ff06", status_rdata);
        end
        step(1, STAT, 32'h3, 1, 1);
        repeat (DEPTH + 2) step(0, 0, 0, 1, 1);
        peek(STAT);
        checks++;
        if (status_rdata !== 32'h1) begin
            failures++;
            $display("FAIL filter_final got %h want 00000001", status_rdata);
        end
    endtask

    task automatic test_random();
        bit g = 0;
        for (int i = 0; i < 400; i++) begin
            int r = $urandom_range(0, 99);
            if (i % 50 == 0) g = $urandom_range(0, 1);
            if (r < 60) step(1, BASE + 32'($urandom_range(0, 32'h3FFFF)), $urandom, $urandom_range(0, 3) == 0, g);
            else if (r < 75) step(1, $urandom_range(0, 1) ? WEND + 32'($urandom_range(0, 1000)) : BASE - 32'($urandom_range(1, 1000)), $urandom, $urandom_range(0, 1), g);
            else if (r < 82) step(1, STAT, $urandom, $urandom_range(0, 1), g);
            else step(0, $urandom, $urandom, $urandom_range(0, 1), g);
            if (i % 10 == 9) begin
                peek(STAT);
                checks++;
                if (status_rdata !== m_status()) begin
                    failures++;
                    $display("FAIL random_status_%0d got %h want %h", i, status_rdata, m_status());
                end
            end
        end
        repeat (DEPTH + 2) step(0, 0, 0, 1, 1);
    endtask

    task automatic test_reset_mid_drain();
        int wens = 0;
        for (int i = 0; i < 8; i++) step(1, BASE + 32'(4 * i + 64), $urandom, 0, 1);
        repeat (2) step(0, 0, 0, 1, 1);
        iobus_wr = 0;
        reset = 1;
        model_clear();
        #1;
        checks++;
        if (vram_wen !== 0 || vram_addr !== 0 || vram_data !== 0) begin
            failures++;
            $display("FAIL async_reset got wen=%b addr=%h data=%h want 0", vram_wen, vram_addr, vram_data);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        peek(STAT);
        checks++;
        if (status_rdata !== 32'h1) begin
            failures++;
            $display("FAIL reset_drain_status got %h want 00000001", status_rdata);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1, 1);
            wens += int'(vram_wen);
        end
        checks++;
        if (wens !== 0) begin
            failures++;
            $display("FAIL stale_after_reset got %0d pulses want 0", wens);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vblank_gate();
        test_overflow();
        test_full_pop();
        test_filter();
        test_random();
        test_reset_mid_drain();
        mon_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
